// File: rtl/segment_driver.sv
// Four-digit hex seven-segment driver with a shadow/active double buffer swapped at the frame boundary.
// Digit ghosting suppression and leading-zero blanking are both selectable by parameter.
module segment_driver #(
    parameter int unsigned BLANK_LZ    = 1,
    parameter int unsigned GHOST_BLANK = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_ctrl,
    input  logic [15:0] i_data,
    input  logic [3:0]  i_dp,
    input  logic        i_load,
    output logic        o_busy,
    output logic [6:0]  o_seg,
    output logic        o_dp
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            4'hF:    hex_to_seg = 7'h0E;
            default: hex_to_seg = SEG_BLANK;
        endcase
    endfunction

    logic [15:0] shadow_data_r;
    logic [3:0]  shadow_dp_r;
    logic [15:0] active_data_r;
    logic [3:0]  active_dp_r;
    logic        pending_r;
    logic [1:0]  prev_ctrl_r;
    logic [6:0]  seg_r;
    logic        dp_r;

    logic        capture_s;
    logic        transfer_s;
    logic [3:0]  nibble_s;
    logic        digit_dp_s;
    logic [3:0]  digit_zero_s;
    logic [3:0]  upper_zero_s;
    logic        lz_blank_s;
    logic        ghost_s;
    logic [6:0]  seg_next_s;
    logic        dp_next_s;

    // Transfer only at the last digit of a frame so a frame never mixes old and new digits
    always_comb begin
        transfer_s = pending_r && (i_ctrl == 2'b11);
        capture_s  = i_load && !pending_r;
    end

    // Shadow capture and shadow-to-active transfer; a load while pending is dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_data_r <= 16'h0000;
            shadow_dp_r   <= 4'h0;
            active_data_r <= 16'h0000;
            active_dp_r   <= 4'h0;
            pending_r     <= 1'b0;
        end else if (transfer_s) begin
            active_data_r <= shadow_data_r;
            active_dp_r   <= shadow_dp_r;
            pending_r     <= 1'b0;
        end else if (capture_s) begin
            shadow_data_r <= i_data;
            shadow_dp_r   <= i_dp;
            pending_r     <= 1'b1;
        end else begin
            pending_r     <= pending_r;
        end
    end

    // Select the nibble and decimal point of the digit currently being scanned
    always_comb begin
        nibble_s   = 4'h0;
        digit_dp_s = 1'b0;
        case (i_ctrl)
            2'd0: begin
                nibble_s   = active_data_r[3:0];
                digit_dp_s = active_dp_r[0];
            end
            2'd1: begin
                nibble_s   = active_data_r[7:4];
                digit_dp_s = active_dp_r[1];
            end
            2'd2: begin
                nibble_s   = active_data_r[11:8];
                digit_dp_s = active_dp_r[2];
            end
            2'd3: begin
                nibble_s   = active_data_r[15:12];
                digit_dp_s = active_dp_r[3];
            end
            default: begin
                nibble_s   = 4'h0;
                digit_dp_s = 1'b0;
            end
        endcase
    end

    // A digit with a lit decimal point counts as significant for blanking purposes
    always_comb begin
        digit_zero_s[0] = (active_data_r[3:0]   == 4'h0) && !active_dp_r[0];
        digit_zero_s[1] = (active_data_r[7:4]   == 4'h0) && !active_dp_r[1];
        digit_zero_s[2] = (active_data_r[11:8]  == 4'h0) && !active_dp_r[2];
        digit_zero_s[3] = (active_data_r[15:12] == 4'h0) && !active_dp_r[3];
        upper_zero_s[3] = digit_zero_s[3];
        upper_zero_s[2] = digit_zero_s[3] && digit_zero_s[2];
        upper_zero_s[1] = digit_zero_s[3] && digit_zero_s[2] && digit_zero_s[1];
        upper_zero_s[0] = 1'b0;
    end

    // Leading-zero blank decision; the rightmost digit always shows a value
    always_comb begin
        lz_blank_s = 1'b0;
        if (BLANK_LZ != 32'd0) begin
            case (i_ctrl)
                2'd1:    lz_blank_s = upper_zero_s[1];
                2'd2:    lz_blank_s = upper_zero_s[2];
                2'd3:    lz_blank_s = upper_zero_s[3];
                default: lz_blank_s = 1'b0;
            endcase
        end else begin
            lz_blank_s = 1'b0;
        end
    end

    // Ghost blanking overrides everything else for the cycle after a digit change
    always_comb begin
        ghost_s    = (GHOST_BLANK != 32'd0) && (i_ctrl != prev_ctrl_r);
        seg_next_s = SEG_BLANK;
        dp_next_s  = 1'b1;
        if (ghost_s || lz_blank_s) begin
            seg_next_s = SEG_BLANK;
            dp_next_s  = 1'b1;
        end else begin
            seg_next_s = hex_to_seg(nibble_s);
            dp_next_s  = ~digit_dp_s;
        end
    end

    // Previous digit index for change detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_ctrl_r <= 2'b00;
        end else begin
            prev_ctrl_r <= i_ctrl;
        end
    end

    // Registered segment outputs, dark while in reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= seg_next_s;
            dp_r  <= dp_next_s;
        end
    end

    assign o_busy = pending_r;
    assign o_seg  = seg_r;
    assign o_dp   = dp_r;

endmodule

// File: tb/tb_segment_driver.sv
// Bench for segment_driver: two instances (default parameters, and both features off) against one
// behavioural display model, plus directed literal expectations.
module tb_segment_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        busy0, busy1, dp0, dp1;
    logic [6:0]  seg0, seg1;
    logic        chk_en = 1'b0;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    segment_driver #(.BLANK_LZ(1), .GHOST_BLANK(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ctrl(ctrl), .i_data(data), .i_dp(dp),
        .i_load(load), .o_busy(busy0), .o_seg(seg0), .o_dp(dp0)
    );

    segment_driver #(.BLANK_LZ(0), .GHOST_BLANK(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ctrl(ctrl), .i_data(data), .i_dp(dp),
        .i_load(load), .o_busy(busy1), .o_seg(seg1), .o_dp(dp1)
    );

    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state
    logic [15:0] m_sh_data, m_act_data;
    logic [3:0]  m_sh_dp, m_act_dp;
    logic        m_pend;
    logic [1:0]  m_prev;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1;

    // Leftmost digit that carries anything worth showing (0 if none)
    function automatic int lead_digit();
        for (int n = 3; n > 0; n--) begin
            if ((((m_act_data >> (4 * n)) & 16'h000F) != 16'h0000) || m_act_dp[n])
                return n;
        end
        return 0;
    endfunction

    function automatic logic [7:0] expect_out(input bit ghost, input bit lz, input logic [1:0] c);
        logic [15:0] nib;
        if (ghost && (c != m_prev))
            return {7'h7F, 1'b1};
        if (lz && (int'(c) > lead_digit()))
            return {7'h7F, 1'b1};
        nib = (m_act_data >> (4 * c)) & 16'h000F;
        return {SEG_TAB[nib[3:0]], ~m_act_dp[c]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sh_data <= 16'h0000; m_sh_dp <= 4'h0;
            m_act_data <= 16'h0000; m_act_dp <= 4'h0;
            m_pend <= 1'b0; m_prev <= 2'b00;
            e_seg0 <= 7'h7F; e_dp0 <= 1'b1;
            e_seg1 <= 7'h7F; e_dp1 <= 1'b1;
        end else begin
            {e_seg0, e_dp0} <= expect_out(1'b1, 1'b1, ctrl);
            {e_seg1, e_dp1} <= expect_out(1'b0, 1'b0, ctrl);
            m_prev <= ctrl;
            if (m_pend && ctrl == 2'b11) begin
                m_act_data <= m_sh_data;
                m_act_dp   <= m_sh_dp;
                m_pend     <= 1'b0;
            end else if (load && !m_pend) begin
                m_sh_data <= data;
                m_sh_dp   <= dp;
                m_pend    <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy0", {31'd0, busy0}, {31'd0, m_pend});
            check("model_seg0",  {25'd0, seg0},  {25'd0, e_seg0});
            check("model_dp0",   {31'd0, dp0},   {31'd0, e_dp0});
            check("model_busy1", {31'd0, busy1}, {31'd0, m_pend});
            check("model_seg1",  {25'd0, seg1},  {25'd0, e_seg1});
            check("model_dp1",   {31'd0, dp1},   {31'd0, e_dp1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [1:0] n, input logic [6:0] es, input logic ed);
        bit changed;
        changed = (ctrl != n);
        ctrl = n;
        tick();
        if (changed) check("ghost_seg0", {25'd0, seg0}, 32'h7F);
        tick();
        check("digit_seg0", {25'd0, seg0}, {25'd0, es});
        check("digit_dp0",  {31'd0, dp0},  {31'd0, ed});
    endtask

    initial begin
        load = 1'b0; ctrl = 2'd0; data = 16'h0000; dp = 4'h0;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) tick();
        check("rst_seg0",  {25'd0, seg0},  32'h7F);
        check("rst_dp0",   {31'd0, dp0},   32'h1);
        check("rst_busy0", {31'd0, busy0}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_seg0", {25'd0, seg0}, 32'h40);
        check("post_rst_dp0",  {31'd0, dp0},  32'h1);

        // Load 1234, then a second load that must be dropped
        data = 16'h1234; dp = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        check("busy_after_load", {31'd0, busy0}, 32'h1);
        data = 16'hFFFF; dp = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        ctrl = 2'd1; tick();
        ctrl = 2'd2; tick();
        check("busy_before_xfer", {31'd0, busy0}, 32'h1);
        ctrl = 2'd3; tick();
        check("busy_after_xfer", {31'd0, busy0}, 32'h0);
        show(2'd0, 7'h19, 1'b1);
        show(2'd1, 7'h30, 1'b1);
        show(2'd2, 7'h24, 1'b0);
        show(2'd3, 7'h79, 1'b1);

        // Ghost blanking on dut0 only
        ctrl = 2'd0; tick();
        check("ghost0_30", {25'd0, seg0}, 32'h7F);
        check("noghost1_30", {25'd0, seg1}, 32'h19);
        tick();
        check("steady0_0", {25'd0, seg0}, 32'h19);
        ctrl = 2'd1; tick();
        check("ghost0_01", {25'd0, seg0}, 32'h7F);
        check("noghost1_01", {25'd0, seg1}, 32'h30);
        tick();
        check("steady0_1", {25'd0, seg0}, 32'h30);

        // Leading-zero blanking of 0005
        data = 16'h0005; dp = 4'h0; load = 1'b1;
        tick();
        load = 1'b0; ctrl = 2'd3;
        tick();
        show(2'd0, 7'h12, 1'b1);
        show(2'd1, 7'h7F, 1'b1);
        show(2'd2, 7'h7F, 1'b1);
        show(2'd3, 7'h7F, 1'b1);
        check("nolz1_d3", {25'd0, seg1}, 32'h40);

        // 0005 with dp on digit 3; a load on the transfer edge is dropped
        data = 16'h0005; dp = 4'b1000; load = 1'b1;
        tick();
        check("busy_dp_load", {31'd0, busy0}, 32'h1);
        data = 16'hFFFF; dp = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        check("load_on_xfer_ignored", {31'd0, busy0}, 32'h0);
        show(2'd0, 7'h12, 1'b1);
        show(2'd1, 7'h40, 1'b1);
        show(2'd2, 7'h40, 1'b1);
        show(2'd3, 7'h40, 1'b0);

        // Reset while a capture is pending
        ctrl = 2'd0; tick(); tick();
        data = 16'hABCD; dp = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        check("busy_before_rst", {31'd0, busy0}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy0}, 32'h0);
        check("async_rst_seg",  {25'd0, seg0},  32'h7F);
        check("async_rst_dp",   {31'd0, dp0},   32'h1);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst2_seg0", {25'd0, seg0}, 32'h40);
        show(2'd1, 7'h7F, 1'b1);
        show(2'd2, 7'h7F, 1'b1);
        show(2'd3, 7'h7F, 1'b1);
        tick(); tick();
        check("no_stale_busy", {31'd0, busy0}, 32'h0);
        show(2'd0, 7'h40, 1'b1);
        check("no_stale_seg1", {25'd0, seg1}, 32'h40);

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
